// File: rtl/ofm_drain_pkg.sv
// Shared definitions for the output-feature-map drain: FSM states, accumulator
// sizing and the saturation limits used by the clamp stage.
package ofm_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } drain_state_e;

  localparam int DEF_DATA_WIDTH = 16;

  // Three guard bits hold the sum of up to eight full-scale partial sums.
  localparam int ACC_GUARD = 3;
  localparam int ACC_WIDTH = DEF_DATA_WIDTH + ACC_GUARD;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((64'sd1 <<< (DEF_DATA_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-(64'sd1 <<< (DEF_DATA_WIDTH - 1)));

  function automatic int acc_width(input int data_width);
    return data_width + ACC_GUARD;
  endfunction

  function automatic longint sat_max(input int data_width);
    return (longint'(1) <<< (data_width - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int data_width);
    return -(longint'(1) <<< (data_width - 1));
  endfunction

endpackage

// File: rtl/ofm_drain_if.sv
// FIFO read port plus result stream of the drain. The drain is the master;
// the FIFO/consumer side is the slave.
interface ofm_drain_if #(
  parameter int DATA_WIDTH = 16
) ();

  logic                  fifo_empty;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_in;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_row_last;
  logic                  out_frame_last;

  modport master (
    input  fifo_empty, data_in, out_ready,
    output rd_en, out_valid, out_data, out_row_last, out_frame_last
  );

  modport slave (
    output fifo_empty, data_in, out_ready,
    input  rd_en, out_valid, out_data, out_row_last, out_frame_last
  );

endinterface

// File: rtl/ofm_drain_sat_relu.sv
// Combinational clamp of a wide accumulator to the signed output range,
// followed by an optional ReLU.
module ofm_sat_relu
  import ofm_drain_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_W      = acc_width(DATA_WIDTH)
) (
  input  logic signed [ACC_W-1:0]      sum,
  input  logic                         relu,
  output logic signed [DATA_WIDTH-1:0] result
);

  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(sat_max(DATA_WIDTH));
  localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(sat_min(DATA_WIDTH));

  // NOTE: every path assigns result first, so no latch can be inferred.
  always_comb begin
    result = '0;
    if (relu && sum[ACC_W-1]) begin
      result = '0;
    end else if (sum > MAX_V) begin
      result = MAX_V[DATA_WIDTH-1:0];
    end else if (sum < MIN_V) begin
      result = MIN_V[DATA_WIDTH-1:0];
    end else begin
      result = sum[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/ofm_drain.sv
// Drains KERNEL_SIZE partial sums per pixel from the accelerator output FIFO,
// reduces them to one clamped pixel and streams the map out with row/frame tags.
module ofm_drain
  import ofm_drain_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int KERNEL_SIZE = 3,
  parameter int INDEX_WIDTH = 4
) (
  input  logic                   clk1,
  input  logic                   rst,
  input  logic                   start,
  input  logic [INDEX_WIDTH-1:0] cfg_cols,
  input  logic [INDEX_WIDTH-1:0] cfg_rows,
  input  logic                   cfg_relu,
  output logic                   busy,
  output logic                   frame_done,
  ofm_drain_if.master            bus
);

  localparam int              ACC_W  = acc_width(DATA_WIDTH);
  localparam int              KW     = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam logic [KW-1:0]   K_LAST = KW'(KERNEL_SIZE - 1);
  localparam int              PW     = 2 * INDEX_WIDTH;

  drain_state_e state_q, state_d;

  logic [INDEX_WIDTH-1:0] cols_q, rows_q, col_q, row_q;
  logic [INDEX_WIDTH-1:0] cols_eff, rows_eff;
  logic                   relu_q;
  logic [KW-1:0]          iss_cnt, cap_cnt;
  logic [PW-1:0]          pix_left;
  logic                   rd_en_d, rd_q, rd_last_q;

  logic signed [ACC_W-1:0]      acc_q, data_ext, sum_next;
  logic signed [DATA_WIDTH-1:0] sat_result, out_data_q;
  logic                         out_valid_q, frame_done_q;

  logic start_ok, stall, xfer, iss_last, cap_last, col_last, row_last;

  assign cols_eff = (cfg_cols == '0) ? INDEX_WIDTH'(1) : cfg_cols;
  assign rows_eff = (cfg_rows == '0) ? INDEX_WIDTH'(1) : cfg_rows;

  // The frame_done cycle is still busy, so a start landing there is dropped.
  assign start_ok = start && (state_q == ST_IDLE) && !frame_done_q;
  assign stall    = out_valid_q && !bus.out_ready;
  assign xfer     = out_valid_q && bus.out_ready;
  assign iss_last = (iss_cnt == K_LAST);
  assign cap_last = (cap_cnt == K_LAST);
  assign col_last = (col_q == cols_q - 1'b1);
  assign row_last = (row_q == rows_q - 1'b1);

  assign data_ext = {{(ACC_W - DATA_WIDTH){bus.data_in[DATA_WIDTH-1]}}, bus.data_in};
  assign sum_next = (cap_cnt == '0) ? data_ext : acc_q + data_ext;

  ofm_sat_relu #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_W      (ACC_W)
  ) u_sat_relu (
    .sum    (sum_next),
    .relu   (relu_q),
    .result (sat_result)
  );

  always_ff @(posedge clk1) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    rd_en_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) state_d = ST_RUN;
      end
      ST_RUN: begin
        // The bubble after a pixel's final word gives the result one cycle to
        // land before the next pixel's reads can be stalled by the consumer.
        rd_en_d = !rst && !bus.fifo_empty && !stall && !rd_last_q;
        if (rd_en_d && iss_last && (pix_left == PW'(1))) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (xfer && bus.out_frame_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      cols_q       <= '0;
      rows_q       <= '0;
      relu_q       <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      iss_cnt      <= '0;
      cap_cnt      <= '0;
      pix_left     <= '0;
      rd_q         <= 1'b0;
      rd_last_q    <= 1'b0;
      acc_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= xfer && bus.out_frame_last;
      rd_q         <= rd_en_d;
      rd_last_q    <= rd_en_d && iss_last;

      if (start_ok) begin
        cols_q   <= cols_eff;
        rows_q   <= rows_eff;
        relu_q   <= cfg_relu;
        pix_left <= PW'(cols_eff) * PW'(rows_eff);
        col_q    <= '0;
        row_q    <= '0;
        iss_cnt  <= '0;
        cap_cnt  <= '0;
      end

      if (rd_en_d) begin
        iss_cnt <= iss_last ? '0 : iss_cnt + 1'b1;
        if (iss_last) pix_left <= pix_left - 1'b1;
      end

      // Capture follows rd_en by one cycle; a word in flight across reset is
      // dropped because rd_q was cleared.
      if (rd_q) begin
        acc_q   <= sum_next;
        cap_cnt <= cap_last ? '0 : cap_cnt + 1'b1;
      end

      if (rd_q && cap_last) begin
        out_valid_q <= 1'b1;
        out_data_q  <= sat_result;
      end else if (xfer) begin
        out_valid_q <= 1'b0;
      end

      if (xfer) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= row_last ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  assign bus.rd_en          = rd_en_d;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_data       = out_data_q;
  assign bus.out_row_last   = out_valid_q && col_last;
  assign bus.out_frame_last = out_valid_q && col_last && row_last;

  assign busy       = (state_q != ST_IDLE) || frame_done_q;
  assign frame_done = frame_done_q;

endmodule
